// File: rtl/vga_frame_capture_if.sv
// VGA pixel stream into vga_frame_capture and the TIFF frame-dump sink signals out of it.
// master: the capture block; slave: the stream source / dump sink side.
interface vga_frame_capture_if;
  logic        vblnk_in;
  logic        hblnk_in;
  logic [11:0] rgb_in;
  logic        pclk_mirror;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        go;
  logic [15:0] xdim;
  logic [15:0] ydim;

  modport master (
    input  vblnk_in, hblnk_in, rgb_in,
    output pclk_mirror, r, g, b, go, xdim, ydim
  );

  modport slave (
    output vblnk_in, hblnk_in, rgb_in,
    input  pclk_mirror, r, g, b, go, xdim, ydim
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Measures one VGA frame, then streams FRAMES frames (0 = continuous) to the TIFF dump sink.
// Optional VGA_CAPTURE_CHECK_EN: per-frame strobe count is checked against xdim*ydim (err).
module vga_frame_capture #(
  parameter int unsigned FRAMES = 1
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       enable,
  vga_frame_capture_if.master        cap,
  output logic                       busy,
  output logic [7:0]                 frames_done,
  output logic                       err
);

  typedef enum logic [2:0] {StIdle, StMeasure, StArm, StCapture, StFinish} state_e;

  state_e      state_q, state_d;
  logic        vblnk_prev_q, hblnk_prev_q;
  logic [15:0] meas_x_q, meas_x_d, meas_y_q, meas_y_d;
  logic [15:0] xdim_q, xdim_d, ydim_q, ydim_d;
  logic [1:0]  flush_q, flush_d;
  logic [15:0] run_q, run_d;
  logic [7:0]  frames_done_q, frames_done_d;
  logic        go_q, go_d;
  logic        valid_q, valid_d;
  logic [11:0] rgb_q, rgb_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic        gate_q, gate_d;

  logic        active, frame_start, frame_end, line_start;
  logic        close_pulse, run_done;
  logic [15:0] run_next;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign active      = ~cap.vblnk_in & ~cap.hblnk_in;
  assign frame_start = vblnk_prev_q & ~cap.vblnk_in;
  assign frame_end   = ~vblnk_prev_q & cap.vblnk_in;
  // A frame that opens straight into active video also starts its first line.
  assign line_start  = active & (hblnk_prev_q | vblnk_prev_q);

  assign run_next = sat_inc16(run_q);
  assign run_done = (FRAMES != 0) && ({16'd0, run_next} >= FRAMES);

  always_comb begin
    state_d     = state_q;
    flush_d     = flush_q;
    run_d       = run_q;
    go_d        = 1'b0;
    close_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        run_d = '0;
        if (enable && frame_start) state_d = StMeasure;
      end
      StMeasure: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (frame_end) begin
          state_d = (meas_x_q == '0 || meas_y_q == '0) ? StIdle : StArm;
        end
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (frame_start) begin
          state_d = StCapture;
          go_d    = 1'b1;
        end
      end
      StCapture: begin
        if (frame_end) begin
          state_d = StFinish;
          flush_d = 2'd3;
        end
      end
      StFinish: begin
        if (flush_q == 2'd1) begin
          close_pulse = 1'b1;
          go_d        = 1'b1;
          run_d       = run_next;
          state_d     = (run_done || !enable) ? StIdle : StArm;
        end else begin
          flush_d = flush_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Measurement counters restart whenever MEASURE is (re)entered.
  always_comb begin
    meas_x_d = (state_q == StMeasure) ? meas_x_q : '0;
    meas_y_d = (state_q == StMeasure) ? meas_y_q : '0;
    if (state_d == StMeasure) begin
      if (line_start) meas_y_d = sat_inc16(meas_y_d);
      if (active && meas_y_d == 16'd1) meas_x_d = sat_inc16(meas_x_d);
    end
    xdim_d = xdim_q;
    ydim_d = ydim_q;
    if (state_q == StMeasure && state_d == StArm) begin
      xdim_d = meas_x_q;
      ydim_d = meas_y_q;
    end
  end

  always_comb begin
    frames_done_d = frames_done_q + {7'd0, close_pulse};
    valid_d       = active && (state_d == StCapture);
    rgb_d         = cap.rgb_in;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    if (valid_q) begin
      r_d = {rgb_q[11:8], rgb_q[11:8]};
      g_d = {rgb_q[7:4], rgb_q[7:4]};
      b_d = {rgb_q[3:0], rgb_q[3:0]};
    end
    gate_d = valid_q;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      vblnk_prev_q  <= 1'b0;
      hblnk_prev_q  <= 1'b0;
      meas_x_q      <= '0;
      meas_y_q      <= '0;
      xdim_q        <= '0;
      ydim_q        <= '0;
      flush_q       <= '0;
      run_q         <= '0;
      frames_done_q <= '0;
      go_q          <= 1'b0;
      valid_q       <= 1'b0;
      rgb_q         <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      state_q       <= state_d;
      vblnk_prev_q  <= cap.vblnk_in;
      hblnk_prev_q  <= cap.hblnk_in;
      meas_x_q      <= meas_x_d;
      meas_y_q      <= meas_y_d;
      xdim_q        <= xdim_d;
      ydim_q        <= ydim_d;
      flush_q       <= flush_d;
      run_q         <= run_d;
      frames_done_q <= frames_done_d;
      go_q          <= go_d;
      valid_q       <= valid_d;
      rgb_q         <= rgb_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  // Gate changes only while pclk is low, so the mirrored clock cannot glitch.
  always_ff @(negedge pclk or posedge rst) begin
    if (rst) begin
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate_d;
    end
  end

`ifdef VGA_CAPTURE_CHECK_EN
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [31:0] area;
  logic        err_q, err_d;

  assign area = {16'd0, xdim_q} * {16'd0, ydim_q};

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (state_q == StArm && state_d == StCapture) begin
      pix_cnt_d = '0;
    end else if (valid_q && pix_cnt_q != 32'hFFFF_FFFF) begin
      pix_cnt_d = pix_cnt_q + 32'd1;
    end
    err_d = err_q;
    if (close_pulse && pix_cnt_q != area) err_d = 1'b1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      pix_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign cap.pclk_mirror = pclk & gate_q;
  assign cap.r           = r_q;
  assign cap.g           = g_q;
  assign cap.b           = b_q;
  assign cap.go          = go_q;
  assign cap.xdim        = xdim_q;
  assign cap.ydim        = ydim_q;
  assign busy            = (state_q != StIdle);
  assign frames_done     = frames_done_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Bench for vga_frame_capture: FRAMES=1 and FRAMES=0 instances share one randomized VGA stream;
// a frame-level model predicts strobed pixels, go pulses and measured dimensions.
module tb_vga_frame_capture;
  localparam int VB = 3;
`ifdef VGA_CAPTURE_CHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  logic       pclk = 1'b0;
  logic       rst;
  logic       en_a, en_b;
  logic       busy_a, busy_b, err_a, err_b;
  logic [7:0] fd_a, fd_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  int          strobes_a = 0, strobes_b = 0;
  int          first_str_a = 0, last_str_a = 0;
  logic [23:0] first_px_a = '0;
  int          go_n_a = 0, go_n_b = 0;
  int          go_t_a[16];
  int          go_t_b[16];
  int          exp_x_a = 8, exp_y_a = 4, exp_x_b = 0, exp_y_b = 0;

  vga_frame_capture_if cap_a ();
  vga_frame_capture_if cap_b ();

  vga_frame_capture #(.FRAMES(1)) dut_a (
    .pclk(pclk), .rst(rst), .enable(en_a), .cap(cap_a),
    .busy(busy_a), .frames_done(fd_a), .err(err_a)
  );

  vga_frame_capture #(.FRAMES(0)) dut_b (
    .pclk(pclk), .rst(rst), .enable(en_b), .cap(cap_b),
    .busy(busy_b), .frames_done(fd_b), .err(err_b)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [11:0] c);
    return {c[11:8], c[11:8], c[7:4], c[7:4], c[3:0], c[3:0]};
  endfunction

  // Strobe monitors: every falling edge of pclk_mirror must deliver the next expected pixel.
  initial forever begin
    @(negedge cap_a.pclk_mirror);
    if (rst === 1'b0) begin
      if (strobes_a == 0) begin
        first_px_a  = {cap_a.r, cap_a.g, cap_a.b};
        first_str_a = cyc;
      end
      strobes_a++;
      last_str_a = cyc;
      check("a_busy_at_strobe", 32'(busy_a), 32'd1);
      check("a_px_avail", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) check("a_px", 32'({cap_a.r, cap_a.g, cap_a.b}), 32'(exp_a.pop_front()));
    end
  end

  initial forever begin
    @(negedge cap_b.pclk_mirror);
    if (rst === 1'b0) begin
      strobes_b++;
      check("b_px_avail", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) check("b_px", 32'({cap_b.r, cap_b.g, cap_b.b}), 32'(exp_b.pop_front()));
    end
  end

  // go monitors: count pulses (one count per high cycle) and check dimensions held at each.
  initial forever begin
    @(negedge pclk);
    if (cap_a.go === 1'b1) begin
      check("a_xdim_at_go", 32'(cap_a.xdim), 32'(exp_x_a));
      check("a_ydim_at_go", 32'(cap_a.ydim), 32'(exp_y_a));
      if (go_n_a < 16) go_t_a[go_n_a] = cyc;
      go_n_a++;
    end
    if (cap_b.go === 1'b1) begin
      check("b_xdim_at_go", 32'(cap_b.xdim), 32'(exp_x_b));
      check("b_ydim_at_go", 32'(cap_b.ydim), 32'(exp_y_b));
      if (go_n_b < 16) go_t_b[go_n_b] = cyc;
      go_n_b++;
    end
  end

  task automatic drive(input logic v, input logic h, input logic [11:0] px);
    @(posedge pclk);
    #1;
    cap_a.vblnk_in = v;
    cap_a.hblnk_in = h;
    cap_a.rgb_in   = px;
    cap_b.vblnk_in = v;
    cap_b.hblnk_in = h;
    cap_b.rgb_in   = px;
  endtask

  task automatic line(input logic v, input int hb, input int w, input bit pa, input bit pb,
                      input bit fix_first);
    logic [11:0] px;
    for (int i = 0; i < hb; i++) drive(v, 1'b1, 12'($urandom));
    for (int i = 0; i < w; i++) begin
      px = (fix_first && i == 0) ? 12'h18F : 12'($urandom);
      if (!v && pa) exp_a.push_back(expand(px));
      if (!v && pb) exp_b.push_back(expand(px));
      drive(v, 1'b0, px);
    end
  endtask

  task automatic vblank(input int w, input int hb);
    for (int i = 0; i < VB; i++) line(1'b1, hb, w, 1'b0, 1'b0, 1'b0);
  endtask

  // One frame: VB blank lines, then h active lines; short_row loses one pixel to hblank.
  task automatic frame(input int w, input int h, input int hb, input bit pa, input bit pb,
                       input int short_row, input bit fix_first);
    int wl;
    vblank(w, hb);
    for (int row = 0; row < h; row++) begin
      wl = (row == short_row) ? w - 1 : w;
      line(1'b0, hb + w - wl, wl, pa, pb, fix_first && row == 0);
    end
  endtask

  task automatic check_rst_a(input string t);
    check({t, "_mirror"}, 32'(cap_a.pclk_mirror), 32'd0);
    check({t, "_rgb"}, 32'({cap_a.r, cap_a.g, cap_a.b}), 32'd0);
    check({t, "_go"}, 32'(cap_a.go), 32'd0);
    check({t, "_xdim"}, 32'(cap_a.xdim), 32'd0);
    check({t, "_ydim"}, 32'(cap_a.ydim), 32'd0);
    check({t, "_busy"}, 32'(busy_a), 32'd0);
    check({t, "_fdone"}, 32'(fd_a), 32'd0);
    check({t, "_err"}, 32'(err_a), 32'd0);
  endtask

  initial begin
    int w, h, hb, s0, s1, g1;
    rst  = 1'b1;
    en_a = 1'b0;
    en_b = 1'b0;
    cap_a.vblnk_in = 1'b1; cap_a.hblnk_in = 1'b1; cap_a.rgb_in = '0;
    cap_b.vblnk_in = 1'b1; cap_b.hblnk_in = 1'b1; cap_b.rgb_in = '0;
    repeat (3) @(posedge pclk);
    #2;
    check_rst_a("init");
    check("init_b_busy", 32'(busy_b), 32'd0);
    @(negedge pclk);
    rst = 1'b0;

    // FRAMES=1, 8x4: one measure frame, one captured frame, then idle.
    en_a = 1'b1;
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    frame(8, 4, 4, 1'b1, 1'b0, -1, 1'b1);
    vblank(8, 4);
    en_a = 1'b0;
    check("t1_xdim", 32'(cap_a.xdim), 32'd8);
    check("t1_ydim", 32'(cap_a.ydim), 32'd4);
    check("t1_go_count", 32'(go_n_a), 32'd2);
    check("t1_go_spacing", 32'(go_t_a[1] - go_t_a[0]), 32'(4 * 12 + 3));
    check("t1_strobes", 32'(strobes_a), 32'd32);
    check("t1_first_px", 32'(first_px_a), 32'h1188FF);
    check("t1_open_before_strobe", 32'(first_str_a > go_t_a[0]), 32'd1);
    check("t1_strobe_before_close", 32'(last_str_a < go_t_a[1]), 32'd1);
    check("t1_fdone", 32'(fd_a), 32'd1);
    check("t1_busy", 32'(busy_a), 32'd0);
    check("t1_err", 32'(err_a), 32'd0);
    check("t1_queue_left", 32'(exp_a.size()), 32'd0);
    s0 = strobes_a;
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    vblank(8, 4);
    check("t1_idle_strobes", 32'(strobes_a), 32'(s0));
    check("t1_idle_go", 32'(go_n_a), 32'd2);

    // Captured frame one pixel short of the measured 8x4 area.
    en_a = 1'b1;
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    frame(8, 4, 4, 1'b1, 1'b0, 2, 1'b0);
    vblank(8, 4);
    en_a = 1'b0;
    check("t2_strobes", 32'(strobes_a - s0), 32'd31);
    check("t2_fdone", 32'(fd_a), 32'd2);
    check("t2_err", 32'(err_a), 32'(ErrExp));
    check("t2_queue_left", 32'(exp_a.size()), 32'd0);
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    vblank(8, 4);
    check("t2_err_held", 32'(err_a), 32'(ErrExp));

    // FRAMES=0, random geometry: 3 frames continuous, enable dropped inside the 4th.
    w  = $urandom_range(3, 10);
    h  = $urandom_range(2, 5);
    hb = $urandom_range(2, 5);
    exp_x_b = w;
    exp_y_b = h;
    en_b = 1'b1;
    frame(w, h, hb, 1'b0, 1'b0, -1, 1'b0);
    repeat (3) frame(w, h, hb, 1'b0, 1'b1, -1, 1'b0);
    fork
      frame(w, h, hb, 1'b0, 1'b1, -1, 1'b0);
      begin
        repeat ((VB + 1) * (hb + w) + hb + 1) @(posedge pclk);
        #1;
        check("t3_fdone_before_drop", 32'(fd_b), 32'd3);
        check("t3_go_before_drop", 32'(go_n_b), 32'd7);
        en_b = 1'b0;
      end
    join
    vblank(w, hb);
    check("t3_go_count", 32'(go_n_b), 32'd8);
    check("t3_go_spacing", 32'(go_t_b[1] - go_t_b[0]), 32'(h * (hb + w) + 3));
    check("t3_fdone", 32'(fd_b), 32'd4);
    check("t3_busy", 32'(busy_b), 32'd0);
    check("t3_strobes", 32'(strobes_b), 32'(4 * w * h));
    check("t3_queue_left", 32'(exp_b.size()), 32'd0);
    check("t3_xdim", 32'(cap_b.xdim), 32'(w));
    check("t3_ydim", 32'(cap_b.ydim), 32'(h));
    s0 = strobes_b;
    frame(w, h, hb, 1'b0, 1'b0, -1, 1'b0);
    vblank(w, hb);
    check("t3_idle_strobes", 32'(strobes_b), 32'(s0));

    // Reset in the middle of a captured frame.
    en_a = 1'b1;
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    s0 = strobes_a;
    s1 = 0;
    g1 = 0;
    fork
      frame(8, 4, 4, 1'b1, 1'b0, -1, 1'b0);
      begin
        repeat ((VB + 1) * 12 + 7) @(posedge pclk);
        #7 rst = 1'b1;
        #1;
        check("t4_strobes_before_rst", 32'(strobes_a > s0), 32'd1);
        check_rst_a("t4_rst");
        check("t4_rst_b_fdone", 32'(fd_b), 32'd0);
        check("t4_rst_b_xdim", 32'(cap_b.xdim), 32'd0);
        s1 = strobes_a;
        g1 = go_n_a;
        @(posedge pclk);
        #2 rst = 1'b0;
      end
    join
    vblank(8, 4);
    en_a = 1'b0;
    frame(8, 4, 4, 1'b0, 1'b0, -1, 1'b0);
    vblank(8, 4);
    check("t4_no_strobes_after_rst", 32'(strobes_a), 32'(s1));
    check("t4_no_close_after_rst", 32'(go_n_a), 32'(g1));
    check("t4_fdone", 32'(fd_a), 32'd0);
    check("t4_busy", 32'(busy_a), 32'd0);
    exp_a.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Captures frames of the 12-bit VGA pixel stream and drives the TIFF frame-dump sink: frame-boundary `go` pulses, a gated pixel strobe `pclk_mirror`, 8-bit-per-channel `r`/`g`/`b`, and the measured `xdim`/`ydim`. It sits at the end of the VGA pipeline, in parallel with the monitor outputs. The first frame after enable is used to measure active-area size. The following frame(s) are streamed out pixel by pixel.

## Interface
- `FRAMES`, default 1: number of frames to capture after measurement; 0 = continuous.
- `pclk` in 1: pixel clock; all logic clocked here.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: level request to start capture.
- `vblnk_in` in 1: vertical blank from the VGA chain.
- `hblnk_in` in 1: horizontal blank from the VGA chain.
- `rgb_in` in 12: pixel colour {R[3:0],G[3:0],B[3:0]}, aligned with blanks.
- `pclk_mirror` out 1: gated copy of `pclk`; one falling edge per captured pixel.
- `r`, `g`, `b` out 8 each: expanded colour, stable at each `pclk_mirror` falling edge.
- `go` out 1: one-cycle pulse; 1st pulse = open frame, 2nd pulse = close frame.
- `xdim`, `ydim` out 16 each: measured active width/height; held during capture.
- `busy` out 1: high in any state other than IDLE.
- `frames_done` out 8: frames closed since reset; wraps at 255→0.
- `err` out 1: sticky pixel-count mismatch (see Configuration).

## Operation
- Active pixel: `hblnk_in==0 && vblnk_in==0`. Frame start = `vblnk_in` 1→0 edge; frame end = 0→1 edge; line start = `hblnk_in` 1→0 edge during active lines.
- Colour expansion is nibble replication: `r={R,R}`, `g={G,G}`, `b={B,B}` (4'h8→8'h88, 4'hF→8'hFF).
- FSM states:
  - IDLE: `enable` and frame start → MEASURE.
  - MEASURE: `xdim` = active pixels on the first line; `ydim` = number of line starts. At frame end: if either count is 0 → IDLE, else → ARM. `enable`=0 → IDLE.
  - ARM: at frame start, pulse `go` → CAPTURE. `enable`=0 → IDLE.
  - CAPTURE: stream active pixels. At frame end → FINISH, and the flush counter loads 3.
  - FINISH: counts 3 cycles, then pulses `go` and increments `frames_done`. Next state is IDLE if `FRAMES!=0` and `FRAMES` frames are closed in this run, or if `enable`=0; otherwise ARM.
- Counters are 16-bit and saturate at 16'hFFFF.
- `enable` dropping in CAPTURE/FINISH does not truncate the frame; the close pulse is always issued.

## Timing
- Stage 1 (posedge N): register `valid_q = active && state==CAPTURE` and `rgb_q`.
- Gate (negedge of cycle N): `gate_n <= valid_q`. `pclk_mirror = pclk & gate_n`, so the enable only changes while `pclk` is low and the output is glitch-free.
- Stage 2 (posedge N+1): `r`/`g`/`b` <= expanded `rgb_q`. The falling edge of `pclk_mirror` in cycle N+1 samples the pixel presented at input edge N.
- Pixel latency: 2 clock edges.
- `go` is registered and high for exactly 1 cycle.
- The open pulse is in the cycle after the frame-start edge, at least 1 cycle before the first `pclk_mirror` falling edge.
- The close pulse comes 3 cycles after the frame-end edge, after the last pixel strobe.
- `xdim`/`ydim` are updated only at the end of MEASURE, and are stable before and through every `go`.
- `rst` asserted at any time: all flops including the negedge gate clear immediately. State → IDLE.
- Reset values: `pclk_mirror`=0, `r`=`g`=`b`=0, `go`=0, `xdim`=`ydim`=0, `busy`=0, `frames_done`=0, `err`=0.
- Reset mid-capture issues no close pulse.

## Configuration
- `VGA_CAPTURE_CHECK_EN` defined:
  - A 32-bit counter counts strobed pixels per captured frame.
  - At the close pulse it is compared with `xdim*ydim` (32-bit product).
  - On mismatch, `err` sets and stays set until `rst`.
- Not defined: no counter is built and `err` is tied to 0.

## Test plan
- 8×4 active area, 4-cycle hblank, 3-line vblank, `FRAMES`=1, `enable`=1:
  - `xdim`=8, `ydim`=4.
  - Exactly two `go` pulses, one frame apart.
  - 32 `pclk_mirror` falling edges; `frames_done`=1; `busy`=0 afterwards.
- Pixel ramp `rgb_in`=12'h18F on the first active pixel → first strobe samples `r`=8'h11, `g`=8'h88, `b`=8'hFF.
- Pipeline flush: the last active pixel's strobe lands before the close `go` pulse; no strobes occur outside CAPTURE.
- `FRAMES`=0:
  - 3 frames captured → 6 `go` pulses; `frames_done`=3.
  - Dropping `enable` mid-frame completes that frame, then the block returns to IDLE.
- `rst` pulsed mid-CAPTURE → every output returns to its reset value within the same time step; no further strobes.
- With `VGA_CAPTURE_CHECK_EN`: after measuring 8×4, shrink the next frame to 7 pixels on one line → `err`=1 after the close pulse and held; without the macro `err` stays 0.
